// File: rtl/uart_frac_baud_gen.sv
// uart_frac_baud_gen
//   Fractional UART baud tick generator. A runtime-programmable divisor
//   (integer + FRAC_W-bit fraction, in system clocks per sub-tick) drives two
//   identical tick chains running at OVERSAMPLE x baud:
//     - TX chain: exposes one pulse per bit period (tx_tick).
//     - RX chain: exposes every sub-tick, the mid-bit and the end-of-bit
//       pulses; its phase can be restarted by rx_resync on a start-bit edge.
//   A new divisor is staged as "pending" and swapped in on a TX bit boundary
//   (or immediately while disabled), so a bit in flight is never distorted.
//
// Ports
//   clk_50mhz    in   system clock, rising edge
//   rst          in   synchronous reset, active-high
//   en           in   enable; low holds both chains cleared
//   cfg_wr       in   one-cycle divisor write strobe
//   cfg_div_int  in   integer clocks per sub-tick (legal >= 2)
//   cfg_div_frac in   fractional clocks per sub-tick, units of 2^-FRAC_W
//   cfg_busy     out  written divisor pending, not yet active
//   cfg_err      out  one-cycle pulse when a write is rejected
//   rx_resync    in   one-cycle pulse, restarts RX chain phase
//   tx_tick      out  one pulse per TX bit period
//   rx_tick      out  one pulse per RX sub-tick
//   rx_mid_tick  out  one pulse at RX half-bit
//   rx_bit_tick  out  one pulse at RX end-of-bit
module uart_frac_baud_gen #(
  parameter int FSYS_CLK   = 50_000_000,
  parameter int BAND_SET   = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4,
  parameter int DEF_INT    = FSYS_CLK / (BAND_SET * OVERSAMPLE),
  parameter int DEF_FRAC   = ((FSYS_CLK - DEF_INT * BAND_SET * OVERSAMPLE) * (2 ** FRAC_W)
                              + (BAND_SET * OVERSAMPLE) / 2) / (BAND_SET * OVERSAMPLE)
) (
  input  logic              clk_50mhz,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_wr,
  input  logic [DIV_W-1:0]  cfg_div_int,
  input  logic [FRAC_W-1:0] cfg_div_frac,
  output logic              cfg_busy,
  output logic              cfg_err,
  input  logic              rx_resync,
  output logic              tx_tick,
  output logic              rx_tick,
  output logic              rx_mid_tick,
  output logic              rx_bit_tick
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0]  OS_ONE   = OS_W'(1);
  localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [DIV_W-1:0] SUB_ONE  = DIV_W'(1);
  localparam logic [DIV_W:0]   LIM_ONE  = (DIV_W + 1)'(1);
  localparam logic [DIV_W-1:0] INT_MIN  = DIV_W'(2);

  // Divisor configuration
  logic [DIV_W-1:0]  act_int_q,  act_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [DIV_W-1:0]  pend_int_q, pend_int_d;
  logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  // TX chain
  logic [DIV_W-1:0]  tx_sub_q, tx_sub_d;
  logic [FRAC_W-1:0] tx_acc_q, tx_acc_d;
  logic              tx_c_q, tx_c_d;
  logic [OS_W-1:0]   tx_os_q, tx_os_d;

  // RX chain
  logic [DIV_W-1:0]  rx_sub_q, rx_sub_d;
  logic [FRAC_W-1:0] rx_acc_q, rx_acc_d;
  logic              rx_c_q, rx_c_d;
  logic [OS_W-1:0]   rx_os_q, rx_os_d;

  // Registered outputs
  logic tx_tick_q, tx_tick_d;
  logic rx_tick_q, rx_tick_d;
  logic rx_mid_q, rx_mid_d;
  logic rx_bit_q, rx_bit_d;

  logic [DIV_W:0]    tx_lim_m1, rx_lim_m1;
  logic [FRAC_W:0]   tx_sum, rx_sum;
  logic              tx_hit, rx_hit, rx_hit_eff, tx_bnd;
  logic              cfg_ok, apply;

  always_comb begin
    // Interval limit is div_int + carry; compared one bit wider so a
    // maximal div_int plus carry cannot wrap.
    tx_lim_m1 = {1'b0, act_int_q} + {{DIV_W{1'b0}}, tx_c_q} - LIM_ONE;
    rx_lim_m1 = {1'b0, act_int_q} + {{DIV_W{1'b0}}, rx_c_q} - LIM_ONE;
    // ">=" rather than "==": when a smaller divisor is applied mid-interval
    // the RX counter may already be past the new limit; it then ticks at once.
    tx_hit    = en && ({1'b0, tx_sub_q} >= tx_lim_m1);
    rx_hit    = en && ({1'b0, rx_sub_q} >= rx_lim_m1);
    rx_hit_eff = rx_hit && !rx_resync;
    tx_sum    = {1'b0, tx_acc_q} + {1'b0, act_frac_q};
    rx_sum    = {1'b0, rx_acc_q} + {1'b0, act_frac_q};
    tx_bnd    = tx_hit && (tx_os_q == OS_LAST);

    tx_sub_d = tx_sub_q;
    tx_acc_d = tx_acc_q;
    tx_c_d   = tx_c_q;
    tx_os_d  = tx_os_q;
    if (!en) begin
      tx_sub_d = '0;
      tx_acc_d = '0;
      tx_c_d   = 1'b0;
      tx_os_d  = '0;
    end else if (tx_hit) begin
      tx_sub_d = '0;
      tx_acc_d = tx_sum[FRAC_W-1:0];
      tx_c_d   = tx_sum[FRAC_W];
      tx_os_d  = tx_os_q + OS_ONE;
    end else begin
      tx_sub_d = tx_sub_q + SUB_ONE;
    end

    rx_sub_d = rx_sub_q;
    rx_acc_d = rx_acc_q;
    rx_c_d   = rx_c_q;
    rx_os_d  = rx_os_q;
    if (!en || rx_resync) begin
      rx_sub_d = '0;
      rx_acc_d = '0;
      rx_c_d   = 1'b0;
      rx_os_d  = '0;
    end else if (rx_hit) begin
      rx_sub_d = '0;
      rx_acc_d = rx_sum[FRAC_W-1:0];
      rx_c_d   = rx_sum[FRAC_W];
      rx_os_d  = rx_os_q + OS_ONE;
    end else begin
      rx_sub_d = rx_sub_q + SUB_ONE;
    end

    tx_tick_d = tx_bnd;
    rx_tick_d = rx_hit_eff;
    rx_mid_d  = rx_hit_eff && (rx_os_q == OS_MID);
    rx_bit_d  = rx_hit_eff && (rx_os_q == OS_LAST);

    // The divisor in use for this edge's arithmetic is the old one; the
    // pending value takes over from the following cycle.
    cfg_ok = cfg_wr && (cfg_div_int >= INT_MIN);
    apply  = busy_q && (tx_bnd || !en);

    act_int_d   = apply ? pend_int_q  : act_int_q;
    act_frac_d  = apply ? pend_frac_q : act_frac_q;
    pend_int_d  = cfg_ok ? cfg_div_int  : pend_int_q;
    pend_frac_d = cfg_ok ? cfg_div_frac : pend_frac_q;
    // A write landing on the apply edge stays pending for the next boundary.
    busy_d      = cfg_ok ? 1'b1 : (apply ? 1'b0 : busy_q);
    err_d       = cfg_wr && !cfg_ok;
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      act_int_q   <= DIV_W'(DEF_INT);
      act_frac_q  <= FRAC_W'(DEF_FRAC);
      pend_int_q  <= DIV_W'(DEF_INT);
      pend_frac_q <= FRAC_W'(DEF_FRAC);
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      tx_sub_q    <= '0;
      tx_acc_q    <= '0;
      tx_c_q      <= 1'b0;
      tx_os_q     <= '0;
      rx_sub_q    <= '0;
      rx_acc_q    <= '0;
      rx_c_q      <= 1'b0;
      rx_os_q     <= '0;
      tx_tick_q   <= 1'b0;
      rx_tick_q   <= 1'b0;
      rx_mid_q    <= 1'b0;
      rx_bit_q    <= 1'b0;
    end else begin
      act_int_q   <= act_int_d;
      act_frac_q  <= act_frac_d;
      pend_int_q  <= pend_int_d;
      pend_frac_q <= pend_frac_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      tx_sub_q    <= tx_sub_d;
      tx_acc_q    <= tx_acc_d;
      tx_c_q      <= tx_c_d;
      tx_os_q     <= tx_os_d;
      rx_sub_q    <= rx_sub_d;
      rx_acc_q    <= rx_acc_d;
      rx_c_q      <= rx_c_d;
      rx_os_q     <= rx_os_d;
      tx_tick_q   <= tx_tick_d;
      rx_tick_q   <= rx_tick_d;
      rx_mid_q    <= rx_mid_d;
      rx_bit_q    <= rx_bit_d;
    end
  end

  assign cfg_busy    = busy_q;
  assign cfg_err     = err_q;
  assign tx_tick     = tx_tick_q;
  assign rx_tick     = rx_tick_q;
  assign rx_mid_tick = rx_mid_q;
  assign rx_bit_tick = rx_bit_q;

endmodule

// File: tb/tb_uart_frac_baud_gen.sv
// Testbench for uart_frac_baud_gen. A negedge monitor logs every output
// pulse as (cycle, kind); each scenario pushes the expected events into a
// scoreboard queue and then pops and compares them against the log.
// kind: 0 rx_tick, 1 rx_mid_tick, 2 rx_bit_tick, 3 tx_tick.
module tb_uart_frac_baud_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [15:0] cfg_div_int = '0;
  logic [3:0]  cfg_div_frac = '0;
  logic        cfg_busy, cfg_err;
  logic        rx_resync = 1'b0;
  logic        tx_tick, rx_tick, rx_mid_tick, rx_bit_tick;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit err_seen = 1'b0;

  typedef struct { int t; int k; } ev_t;
  ev_t obs_q[$];
  ev_t exp_q[$];

  uart_frac_baud_gen dut (
    .clk_50mhz   (clk),
    .rst         (rst),
    .en          (en),
    .cfg_wr      (cfg_wr),
    .cfg_div_int (cfg_div_int),
    .cfg_div_frac(cfg_div_frac),
    .cfg_busy    (cfg_busy),
    .cfg_err     (cfg_err),
    .rx_resync   (rx_resync),
    .tx_tick     (tx_tick),
    .rx_tick     (rx_tick),
    .rx_mid_tick (rx_mid_tick),
    .rx_bit_tick (rx_bit_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(int t, int k);
    ev_t e;
    e.t = t;
    e.k = k;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rx_tick)     obs_q.push_back(mk(cyc, 0));
    if (rx_mid_tick) obs_q.push_back(mk(cyc, 1));
    if (rx_bit_tick) obs_q.push_back(mk(cyc, 2));
    if (tx_tick)     obs_q.push_back(mk(cyc, 3));
    if (cfg_err)     err_seen = 1'b1;
  end

  // Expected pulses for both chains starting from zero phase: the first
  // enabled edge is c0+1. Interval n (n>=2) is extended exactly when the
  // running fraction sum (n-1)*frac crosses a multiple of 16.
  function automatic void push_sched(int c0, int dint, int dfrac, int horizon);
    int t = c0;
    for (int n = 1; n < 100000; n++) begin
      t += dint + (((n >= 2) && ((((n - 1) * dfrac) / 16) != (((n - 2) * dfrac) / 16))) ? 1 : 0);
      if (t > horizon) break;
      exp_q.push_back(mk(t, 0));
      if (n % 16 == 8) exp_q.push_back(mk(t, 1));
      if (n % 16 == 0) begin
        exp_q.push_back(mk(t, 2));
        exp_q.push_back(mk(t, 3));
      end
    end
  endfunction

  task automatic run_to(input int h);
    while (cyc < h) @(negedge clk);
    #1;
  endtask

  task automatic wait_tx(output bit got);
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx_tick) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic write_cfg(input int dint, input int dfrac);
    @(negedge clk);
    cfg_wr       = 1'b1;
    cfg_div_int  = 16'(dint);
    cfg_div_frac = 4'(dfrac);
    @(negedge clk);
    cfg_wr       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    n_checks += 6;
    if (rx_tick !== 1'b0)     begin n_fail++; $display("FAIL reset_rx_tick: got %b want 0", rx_tick); end
    if (rx_mid_tick !== 1'b0) begin n_fail++; $display("FAIL reset_rx_mid: got %b want 0", rx_mid_tick); end
    if (rx_bit_tick !== 1'b0) begin n_fail++; $display("FAIL reset_rx_bit: got %b want 0", rx_bit_tick); end
    if (tx_tick !== 1'b0)     begin n_fail++; $display("FAIL reset_tx_tick: got %b want 0", tx_tick); end
    if (cfg_busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b want 0", cfg_busy); end
    if (cfg_err !== 1'b0)     begin n_fail++; $display("FAIL reset_err: got %b want 0", cfg_err); end
  endtask

  task automatic test_default_rate();
    int c0;
    ev_t e, o;
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    c0  = cyc;
    #1;
    obs_q.delete();
    exp_q.delete();
    push_sched(c0, 27, 2, c0 + 5000);
    run_to(c0 + 5000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL default_missing: kind %0d expected at %0d, pulse log empty", e.k, e.t);
      end else begin
        o = obs_q.pop_front();
        if (o.t !== e.t || o.k !== e.k) begin
          n_fail++; $display("FAIL default_sched: got kind %0d at %0d, want kind %0d at %0d", o.k, o.t, e.k, e.t);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL default_extra: %0d extra pulses, want 0", obs_q.size()); end
  endtask

  task automatic test_cfg_apply();
    bit got, early;
    int ta;
    int rxt[$];
    int txt[$];
    err_seen = 1'b0;
    write_cfg(4, 0);
    n_checks++;
    if (cfg_busy !== 1'b1) begin n_fail++; $display("FAIL apply_busy_set: got %b want 1", cfg_busy); end
    got = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx_tick) begin got = 1'b1; break; end
      if (cfg_busy !== 1'b1) early = 1'b1;
    end
    n_checks += 3;
    if (!got)  begin n_fail++; $display("FAIL apply_wait_tx: got no tx_tick, want one within 2000 cycles"); end
    if (early) begin n_fail++; $display("FAIL apply_busy_early: got busy 0 before boundary, want 1"); end
    if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL apply_busy_clear: got %b want 0", cfg_busy); end
    ta = cyc;
    #1;
    obs_q.delete();
    run_to(ta + 300);
    foreach (obs_q[i]) begin
      if (obs_q[i].k == 0) rxt.push_back(obs_q[i].t);
      if (obs_q[i].k == 3) txt.push_back(obs_q[i].t);
    end
    n_checks += 2;
    if (rxt.size() < 60) begin n_fail++; $display("FAIL apply_rx_count: got %0d want >= 60", rxt.size()); end
    if (txt.size() < 4)  begin n_fail++; $display("FAIL apply_tx_count: got %0d want >= 4", txt.size()); end
    for (int i = 3; i + 1 < rxt.size(); i++) begin
      n_checks++;
      if (rxt[i+1] - rxt[i] !== 4) begin n_fail++; $display("FAIL apply_rx_period: got %0d want 4", rxt[i+1] - rxt[i]); end
    end
    for (int i = 0; i + 1 < txt.size(); i++) begin
      n_checks++;
      if (txt[i+1] - txt[i] !== 64) begin n_fail++; $display("FAIL apply_tx_period: got %0d want 64", txt[i+1] - txt[i]); end
    end
    n_checks++;
    if (err_seen !== 1'b0) begin n_fail++; $display("FAIL apply_err: got cfg_err pulse, want none"); end
    obs_q.delete();
  endtask

  task automatic test_cfg_reject_and_overwrite();
    bit got;
    int ta;
    int rxt[$];
    int txt[$];
    write_cfg(1, 3);
    n_checks += 2;
    if (cfg_err !== 1'b1)  begin n_fail++; $display("FAIL reject_err_pulse: got %b want 1", cfg_err); end
    if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL reject_busy: got %b want 0", cfg_busy); end
    @(negedge clk);
    n_checks++;
    if (cfg_err !== 1'b0)  begin n_fail++; $display("FAIL reject_err_single: got %b want 0", cfg_err); end
    // Periods must be unchanged by the rejected write.
    ta = cyc;
    #1;
    obs_q.delete();
    run_to(ta + 200);
    foreach (obs_q[i]) begin
      if (obs_q[i].k == 0) rxt.push_back(obs_q[i].t);
      if (obs_q[i].k == 3) txt.push_back(obs_q[i].t);
    end
    n_checks++;
    if (rxt.size() < 40) begin n_fail++; $display("FAIL reject_rx_count: got %0d want >= 40", rxt.size()); end
    for (int i = 0; i + 1 < rxt.size(); i++) begin
      n_checks++;
      if (rxt[i+1] - rxt[i] !== 4) begin n_fail++; $display("FAIL reject_rx_period: got %0d want 4", rxt[i+1] - rxt[i]); end
    end
    for (int i = 0; i + 1 < txt.size(); i++) begin
      n_checks++;
      if (txt[i+1] - txt[i] !== 64) begin n_fail++; $display("FAIL reject_tx_period: got %0d want 64", txt[i+1] - txt[i]); end
    end
    // Two writes back to back right after a boundary; only the second applies.
    wait_tx(got);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL b2b_wait_tx: got no tx_tick, want one"); end
    cfg_wr = 1'b1; cfg_div_int = 16'd6; cfg_div_frac = 4'd0;
    @(negedge clk);
    cfg_wr = 1'b1; cfg_div_int = 16'd8; cfg_div_frac = 4'd0;
    @(negedge clk);
    cfg_wr = 1'b0;
    n_checks++;
    if (cfg_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", cfg_busy); end
    wait_tx(got);
    ta = cyc;
    #1;
    obs_q.delete();
    rxt.delete();
    txt.delete();
    run_to(ta + 500);
    foreach (obs_q[i]) begin
      if (obs_q[i].k == 0) rxt.push_back(obs_q[i].t);
      if (obs_q[i].k == 3) txt.push_back(obs_q[i].t);
    end
    n_checks += 2;
    if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_clear: got %b want 0", cfg_busy); end
    if (txt.size() < 3)    begin n_fail++; $display("FAIL b2b_tx_count: got %0d want >= 3", txt.size()); end
    for (int i = 3; i + 1 < rxt.size(); i++) begin
      n_checks++;
      if (rxt[i+1] - rxt[i] !== 8) begin n_fail++; $display("FAIL b2b_rx_period: got %0d want 8", rxt[i+1] - rxt[i]); end
    end
    for (int i = 0; i + 1 < txt.size(); i++) begin
      n_checks++;
      if (txt[i+1] - txt[i] !== 128) begin n_fail++; $display("FAIL b2b_tx_period: got %0d want 128", txt[i+1] - txt[i]); end
    end
    obs_q.delete();
  endtask

  task automatic test_resync();
    bit got;
    int tt, er, dly;
    ev_t e, o;
    write_cfg(10, 0);
    for (int i = 0; i < 1000 && cfg_busy; i++) @(negedge clk);
    n_checks++;
    if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL resync_apply: got busy %b want 0", cfg_busy); end
    wait_tx(got);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL resync_wait_tx: got no tx_tick, want one"); end
    tt  = cyc;
    dly = int'($urandom_range(3, 150));
    repeat (dly) @(negedge clk);
    rx_resync = 1'b1;
    er = cyc + 1;
    #1;
    obs_q.delete();
    exp_q.delete();
    for (int t = er; t <= er + 400; t++) begin
      if (t > er && (t - er) % 10 == 0)   exp_q.push_back(mk(t, 0));
      if (t > er && (t - er) % 160 == 80) exp_q.push_back(mk(t, 1));
      if (t > er && (t - er) % 160 == 0)  exp_q.push_back(mk(t, 2));
      if (t > tt && (t - tt) % 160 == 0)  exp_q.push_back(mk(t, 3));
    end
    @(negedge clk);
    rx_resync = 1'b0;
    run_to(er + 400);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL resync_missing: kind %0d expected at %0d, pulse log empty", e.k, e.t);
      end else begin
        o = obs_q.pop_front();
        if (o.t !== e.t || o.k !== e.k) begin
          n_fail++; $display("FAIL resync_sched: got kind %0d at %0d, want kind %0d at %0d", o.k, o.t, e.k, e.t);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL resync_extra: %0d extra pulses, want 0", obs_q.size()); end
  endtask

  task automatic test_enable();
    int c0;
    ev_t e, o;
    @(negedge clk);
    en = 1'b0;
    #1;
    obs_q.delete();
    write_cfg(5, 0);
    n_checks++;
    if (cfg_busy !== 1'b1) begin n_fail++; $display("FAIL en_busy_set: got %b want 1", cfg_busy); end
    @(negedge clk);
    n_checks++;
    if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL en_apply_idle: got busy %b want 0", cfg_busy); end
    repeat (97) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL en_low_ticks: got %0d pulses, want 0", obs_q.size()); end
    en = 1'b1;
    c0 = cyc;
    #1;
    obs_q.delete();
    exp_q.delete();
    push_sched(c0, 5, 0, c0 + 400);
    run_to(c0 + 400);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL en_missing: kind %0d expected at %0d, pulse log empty", e.k, e.t);
      end else begin
        o = obs_q.pop_front();
        if (o.t !== e.t || o.k !== e.k) begin
          n_fail++; $display("FAIL en_sched: got kind %0d at %0d, want kind %0d at %0d", o.k, o.t, e.k, e.t);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL en_extra: %0d extra pulses, want 0", obs_q.size()); end
  endtask

  task automatic test_rst_midbit();
    bit got;
    int c0;
    ev_t e, o;
    wait_tx(got);
    write_cfg(7, 1);
    n_checks++;
    if (cfg_busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy_set: got %b want 1", cfg_busy); end
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks += 5;
    if (rx_tick !== 1'b0)     begin n_fail++; $display("FAIL rst_rx_tick: got %b want 0", rx_tick); end
    if (rx_mid_tick !== 1'b0) begin n_fail++; $display("FAIL rst_rx_mid: got %b want 0", rx_mid_tick); end
    if (rx_bit_tick !== 1'b0) begin n_fail++; $display("FAIL rst_rx_bit: got %b want 0", rx_bit_tick); end
    if (tx_tick !== 1'b0)     begin n_fail++; $display("FAIL rst_tx_tick: got %b want 0", tx_tick); end
    if (cfg_busy !== 1'b0)    begin n_fail++; $display("FAIL rst_busy: got %b want 0", cfg_busy); end
    rst = 1'b0;
    c0  = cyc;
    #1;
    obs_q.delete();
    exp_q.delete();
    push_sched(c0, 27, 2, c0 + 1000);
    run_to(c0 + 1000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL rst_missing: kind %0d expected at %0d, pulse log empty", e.k, e.t);
      end else begin
        o = obs_q.pop_front();
        if (o.t !== e.t || o.k !== e.k) begin
          n_fail++; $display("FAIL rst_sched: got kind %0d at %0d, want kind %0d at %0d", o.k, o.t, e.k, e.t);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL rst_extra: %0d extra pulses, want 0", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_default_rate();
    test_cfg_apply();
    test_cfg_reject_and_overwrite();
    test_resync();
    test_enable();
    test_rst_midbit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frac_baud_gen.md
Name: uart_frac_baud_gen

Overview:
- Next-generation UART baud tick generator.
- Replaces the fixed integer divider with a runtime-programmable fractional divider (integer + FRAC_W-bit fraction) at OVERSAMPLE x baud.
- Drives two independent tick chains from the shared divisor: a TX chain (one pulse per bit) and an RX chain (oversample, mid-bit and end-of-bit pulses, re-phasable on start-bit detect).
- Sits between the system clock and the UART TX/RX shifters.

Parameters:
- FSYS_CLK, 50_000_000: system clock frequency in Hz; used only to compute reset divisor.
- BAND_SET, 115200: reset-default baud rate.
- OVERSAMPLE, 16: sub-ticks per bit; power of two, >=4.
- DIV_W, 16: width of integer divisor.
- FRAC_W, 4: width of fractional divisor.
- DEF_INT, FSYS_CLK/(BAND_SET*OVERSAMPLE): reset integer divisor (27 at defaults).
- DEF_FRAC, round(frac part * 2^FRAC_W): reset fraction (2 at defaults).

Ports:
- clk_50mhz  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  generator enable; low holds both chains cleared.
- cfg_wr  in  1  one-cycle divisor write strobe.
- cfg_div_int  in  DIV_W  integer clocks per sub-tick; legal >=2.
- cfg_div_frac  in  FRAC_W  fractional clocks per sub-tick, in units of 2^-FRAC_W.
- cfg_busy  out  1  written divisor pending, not yet active.
- cfg_err  out  1  one-cycle pulse when cfg_wr is rejected.
- rx_resync  in  1  one-cycle pulse; restarts RX chain phase (start-bit edge).
- tx_tick  out  1  one-cycle pulse per TX bit period.
- rx_tick  out  1  one-cycle pulse per RX sub-tick (OVERSAMPLE per bit).
- rx_mid_tick  out  1  one-cycle pulse at RX half-bit.
- rx_bit_tick  out  1  one-cycle pulse at RX end-of-bit.

Behaviour:
- Reset (rst=1 at an edge):
  - Active divisor = DEF_INT/DEF_FRAC; pending cleared.
  - All counters and fraction accumulators = 0.
  - All outputs = 0.
- Chain structure, identical for TX and RX:
  - Sub-counter sub_cnt[DIV_W], fraction accumulator acc[FRAC_W], oversample counter os_cnt[log2 OVERSAMPLE].
  - Interval limit L = div_int + c, where c is the carry latched at the previous sub-tick (0 after clear).
  - sub_cnt increments on each enabled cycle.
  - When sub_cnt reaches L-1: internal sub-tick, sub_cnt <= 0, {c,acc} <= acc + div_frac (c = carry out), os_cnt increments modulo OVERSAMPLE.
- Outputs are registered and are high the cycle after the internal sub-tick:
  - rx_tick = RX sub-tick.
  - rx_mid_tick = RX sub-tick with os_cnt == OVERSAMPLE/2-1 (before increment).
  - rx_bit_tick = RX sub-tick with os_cnt == OVERSAMPLE-1.
  - tx_tick = TX sub-tick with TX os_cnt == OVERSAMPLE-1.
  - No TX sub-tick output is exposed.
- Timing:
  - Sub-tick spacing is exactly div_int or div_int+1 cycles.
  - Over any 2^FRAC_W consecutive sub-ticks, exactly div_frac intervals are extended.
  - After en rises, or after clear, the first sub-tick is after div_int enabled edges.
- Enable:
  - en=0: all chain state held at 0, no ticks.
  - A tick already registered in the cycle en falls still appears for that one cycle.
- rx_resync:
  - Clears RX sub_cnt, acc, c and os_cnt on that edge; the TX chain is unaffected.
  - Suppresses any RX sub-tick from that same edge.
  - The first rx_mid_tick then follows after (OVERSAMPLE/2)*div_int + extensions cycles.
- Configuration:
  - cfg_wr with cfg_div_int < 2: rejected; cfg_err pulses one cycle; active and pending unchanged.
  - Otherwise the value is captured into pending and cfg_busy=1.
  - A pending value becomes active on the edge that produces a TX bit boundary (TX sub-tick with os_cnt==OVERSAMPLE-1), and applies to both chains from that edge on. Counters are not cleared.
  - If en=0, a pending value becomes active on the next edge.
  - cfg_busy clears on the same edge the value becomes active.
  - A cfg_wr while busy overwrites pending; only the last write applies.
  - A cfg_wr on the same edge as an apply: the new value stays pending (busy remains 1).
- Simultaneous rx_resync and apply on one edge: both take effect; RX restarts with the new divisor.
- Width rule: acc + div_frac is computed at FRAC_W+1 bits. No overflow elsewhere, since sub_cnt <= div_int.

Test Plan:
- Reset defaults, en=1 for 5000 cycles -> first rx_tick 27 cycles after en; tx_tick period exactly 434 cycles; 2 of every 16 rx intervals are 28 cycles; rx_bit_tick every 434 cycles.
- cfg_wr int=4, frac=0 mid-bit -> cfg_busy=1 until next tx_tick edge; afterwards rx_tick every 4 cycles, tx_tick every 64; cfg_err stays 0.
- cfg_wr int=1 -> cfg_err single pulse; cfg_busy=0; tick periods unchanged; two cfg_wr back-to-back while busy -> only the second divisor becomes active.
- rx_resync at arbitrary phase (int=10, frac=0) -> rx_mid_tick exactly 80 cycles later, rx_bit_tick 160 cycles later; tx_tick phase undisturbed.
- en dropped for 100 cycles then raised -> no ticks while low; first rx_tick and tx sub-tick restart from zero phase; a pending cfg is applied during en=0.
- rst asserted mid-bit with pending cfg -> all outputs 0 next cycle, cfg_busy=0, divisor back to 27/2.
